// File: rtl/rover_display_scheduler.sv
// rover_display_scheduler: time-shares one 4-digit display between fault, motion and telemetry sources
module rover_display_scheduler #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        blank,
  output logic [2:0]  done
);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SHOW, FAULT} state_t;
  state_t        state_q;
  logic          sel_q;
  logic          rr_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] blink_q;
  logic          blank_q;
  logic [2:0]    done_q;
  logic [2:0]    grant_q;
  logic [15:0]   frame_q;
  logic          valid_q;
  logic          pick_d;
  logic          dwell_end;
  logic          other_req;
  logic          self_req;
  // sel/rr encode the non-fault source: 0 = source 1, 1 = source 2
  assign pick_d    = rr_q ? !req[1] : req[2];
  assign dwell_end = dwell_q == DWELL_LAST;
  assign other_req = sel_q ? req[1] : req[2];
  assign self_req  = sel_q ? req[2] : req[1];
  assign grant       = grant_q;
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign blank       = blank_q;
  assign done        = done_q;
  // Scheduler FSM plus the display stage that follows the state one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      rr_q    <= 1'b1;
      dwell_q <= '0;
      blink_q <= '0;
      blank_q <= 1'b0;
      done_q  <= 3'b000;
      grant_q <= 3'b000;
      frame_q <= 16'hFFFF;
      valid_q <= 1'b0;
    end else begin
      done_q  <= 3'b000;
      grant_q <= state_q == FAULT ? 3'b001 : state_q == SHOW ? (sel_q ? 3'b100 : 3'b010) : 3'b000;
      frame_q <= state_q == FAULT ? data0 : state_q == SHOW ? (sel_q ? data2 : data1) : 16'hFFFF;
      valid_q <= state_q != IDLE;
      case (state_q)
        IDLE: begin
          if (req[0]) begin
            state_q <= FAULT;
          end else if (req[1] || req[2]) begin
            state_q <= SHOW;
            sel_q   <= pick_d;
            dwell_q <= '0;
          end
        end
        SHOW: begin
          if (dwell_end) begin
            done_q  <= sel_q ? 3'b100 : 3'b010;
            rr_q    <= sel_q;
            dwell_q <= '0;
            if (req[0]) state_q <= FAULT;
            else if (other_req) sel_q <= !sel_q;
            else if (!self_req) state_q <= IDLE;
          end else if (req[0]) begin
            state_q <= FAULT;
            dwell_q <= '0;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        FAULT: begin
          if (!req[0]) begin
            done_q  <= 3'b001;
            blank_q <= 1'b0;
            blink_q <= '0;
            state_q <= (req[1] || req[2]) ? SHOW : IDLE;
            sel_q   <= pick_d;
            dwell_q <= '0;
          end else if (blink_q == BLINK_LAST) begin
            blink_q <= '0;
            blank_q <= !blank_q;
          end else begin
            blink_q <= blink_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
